// File: rtl/ahb_pkg.sv
// Shared AHB transfer/burst encodings, arbiter state type and burst-length helper
// used by ahb_arbiter and its picker.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_INCR  = 2'd2,
      S_LOCK  = 2'd3
   } arb_state_t;

   localparam int BEAT_CNT_WIDTH = 4;

   // Beats in a burst: 0 marks the undefined-length INCR, unknown codes count as SINGLE.
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      logic [4:0] beats;
      case (hburst)
         HBURST_INCR:                  beats = 5'd0;
         HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
         default:                      beats = 5'd1;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational circular picker: first requester at or after ptr wins,
// producing a one-hot grant and a valid flag.
module arb_rr_picker
   import ahb_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [PW-1:0] idx;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter: round-robin grant held across bursts and locked sequences.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int MIDX_WIDTH     = $clog2(NUM_MASTERS),
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MIDX_WIDTH-1:0]  HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MIDX_WIDTH-1:0]  DEF_IDX   = MIDX_WIDTH'(DEFAULT_MASTER);

   arb_state_t                state;
   arb_state_t                next_state;
   arb_state_t                start_state;
   logic [BEAT_CNT_WIDTH-1:0] beats_left;
   logic [BEAT_CNT_WIDTH-1:0] next_beats;
   logic [BEAT_CNT_WIDTH-1:0] start_beats;
   logic [4:0]                start_len;
   logic [MIDX_WIDTH-1:0]     owner;
   logic                      owner_req;
   logic                      owner_lock;
   logic [MIDX_WIDTH-1:0]     pick_ptr;
   logic [NUM_MASTERS-1:0]    pick_grant;
   logic                      pick_valid;
   logic [NUM_MASTERS-1:0]    next_grant;

   always_comb begin
      owner = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (HGRANT[i]) owner = MIDX_WIDTH'(i);
      end
   end

   assign owner_req  = HBUSREQ[owner];
   assign owner_lock = HLOCK[owner];

   arb_rr_picker #(
      .N  (NUM_MASTERS),
      .PW (MIDX_WIDTH)
   ) u_picker (
      .req   (HBUSREQ),
      .ptr   (pick_ptr),
      .grant (pick_grant),
      .valid (pick_valid)
   );

`ifdef AHB_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   localparam logic [MIDX_WIDTH-1:0] LAST_IDX = MIDX_WIDTH'(NUM_MASTERS - 1);
   localparam logic [MIDX_WIDTH-1:0] RST_PTR  = MIDX_WIDTH'((DEFAULT_MASTER + 1) % NUM_MASTERS);

   logic [MIDX_WIDTH-1:0] rr_ptr;
   logic [MIDX_WIDTH-1:0] winner;

   always_comb begin
      winner = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_grant[i]) winner = MIDX_WIDTH'(i);
      end
   end

   // Parking on the default master leaves the rotation untouched.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rr_ptr <= RST_PTR;
      end else if (HREADY && next_state == S_IDLE && pick_valid) begin
         rr_ptr <= (winner == LAST_IDX) ? '0 : winner + MIDX_WIDTH'(1);
      end
   end

   assign pick_ptr = rr_ptr;
`endif

   // What a NONSEQ from the owner starts; lock outranks any burst type.
   always_comb begin
      start_len   = burst_beats(HBURST);
      start_state = S_IDLE;
      start_beats = '0;
      if (owner_lock) begin
         start_state = S_LOCK;
      end else if (start_len == 5'd0) begin
         start_state = S_INCR;
      end else if (start_len > 5'd1) begin
         start_state = S_BURST;
         start_beats = BEAT_CNT_WIDTH'(start_len - 5'd1);
      end
   end

   always_comb begin
      next_state = state;
      next_beats = beats_left;
      case (state)
         S_IDLE: begin
            if (HTRANS == HTRANS_NONSEQ) begin
               next_state = start_state;
               next_beats = start_beats;
            end
         end
         S_BURST: begin
            case (HTRANS)
               HTRANS_NONSEQ: begin
                  next_state = start_state;
                  next_beats = start_beats;
               end
               HTRANS_SEQ: begin
                  if (beats_left <= BEAT_CNT_WIDTH'(1)) next_state = S_IDLE;
                  else                                  next_beats = beats_left - BEAT_CNT_WIDTH'(1);
               end
               HTRANS_IDLE: next_state = S_IDLE;
               default: ;
            endcase
         end
         S_INCR: begin
            if (HTRANS == HTRANS_NONSEQ) begin
               next_state = start_state;
               next_beats = start_beats;
            end else if (!owner_req) begin
               next_state = S_IDLE;
            end
         end
         S_LOCK: begin
            if (!owner_lock && (HTRANS == HTRANS_IDLE || HTRANS == HTRANS_NONSEQ)) begin
               next_state = S_IDLE;
            end
         end
      endcase
      if (next_state == S_IDLE) next_beats = '0;
   end

   always_comb begin
      next_grant = HGRANT;
      if (next_state == S_IDLE) next_grant = pick_valid ? pick_grant : DEF_GRANT;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= S_IDLE;
         beats_left <= '0;
         HGRANT     <= DEF_GRANT;
         HMASTER    <= DEF_IDX;
         HMASTLOCK  <= 1'b0;
      end else if (HREADY) begin
         state      <= next_state;
         beats_left <= next_beats;
         HGRANT     <= next_grant;
         HMASTER    <= owner;
         HMASTLOCK  <= owner_lock;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: stimulus queues hand-computed grant/master/lock
// expectations tagged with a cycle number; a negedge monitor pops and compares them.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic [2:0] HBUSREQ;
   logic [2:0] HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [2:0] HGRANT;
   logic [1:0] HMASTER;
   logic       HMASTLOCK;

   always #5 HCLK = ~HCLK;

   ahb_arbiter #(
      .NUM_MASTERS    (3),
      .MIDX_WIDTH     (2),
      .DEFAULT_MASTER (0)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   int         cyc = 0;
   int         tests_run = 0;
   int         tests_failed = 0;
   int         q_cyc[$];
   logic [5:0] q_val[$];
   string      q_name[$];

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got grant=%b master=%0d lock=%b, required grant=%b master=%0d lock=%b",
                  name, act[5:3], act[2:1], act[0], exp[5:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic expect_at(input int c, input logic [2:0] g, input logic [1:0] m,
                            input logic l, input string name);
      q_cyc.push_back(c);
      q_val.push_back({g, m, l});
      q_name.push_back(name);
   endtask

   task automatic drive(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready);
      HBUSREQ = req;
      HLOCK   = lock;
      HTRANS  = trans;
      HBURST  = burst;
      HREADY  = ready;
   endtask

   // One bus cycle: apply inputs, queue the outputs expected after the coming edge.
   task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic ready,
                       input logic [2:0] g, input logic [1:0] m, input logic l, input string name);
      drive(req, lock, trans, burst, ready);
      expect_at(cyc + 1, g, m, l, name);
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      int         c;
      logic [5:0] v;
      string      n;
      forever begin
         @(negedge HCLK);
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            c = q_cyc.pop_front();
            v = q_val.pop_front();
            n = q_name.pop_front();
            if (c < cyc) begin
               tests_run++;
               tests_failed++;
               $display("FAIL %s: sample for cycle %0d missed (now %0d), required %b", n, c, cyc, v);
            end else begin
               check(n, {HGRANT, HMASTER, HMASTLOCK}, v);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET = 1'b1;
      drive(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      repeat (3) @(posedge HCLK);
      #1;
      expect_at(cyc, 3'b001, 2'd0, 1'b0, "reset_state");
      HRESET = 1'b0;

      // Parking on the default master with no requests.
      for (int i = 0; i < 10; i++)
         step(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 3'b001, 2'd0, 1'b0,
              $sformatf("park_%0d", i));

      // M1 and M2 alternate on SINGLE transfers; HMASTER trails by one cycle.
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b010, 2'd0, 1'b0, "alt_0");
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b100, 2'd1, 1'b0, "alt_1");
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b010, 2'd2, 1'b0, "alt_2");
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b100, 2'd1, 1'b0, "alt_3");
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b010, 2'd2, 1'b0, "alt_4");

      // M1 INCR4 while M2 waits: handover after the fourth address.
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 3'b010, 2'd1, 1'b0, "incr4_b1");
      step(3'b110, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 3'b010, 2'd1, 1'b0, "incr4_b2");
      step(3'b110, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 3'b010, 2'd1, 1'b0, "incr4_b3");
      step(3'b110, 3'b000, HTRANS_SEQ,    HBURST_INCR4, 1'b1, 3'b100, 2'd1, 1'b0, "incr4_handover");
      step(3'b100, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 3'b100, 2'd2, 1'b0, "incr4_hmaster");

      // M2 WRAP8 with three wait states; M1 requesting throughout.
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_WRAP8, 1'b1, 3'b100, 2'd2, 1'b0, "wrap8_b1");
      step(3'b110, 3'b000, HTRANS_SEQ,    HBURST_WRAP8, 1'b1, 3'b100, 2'd2, 1'b0, "wrap8_b2");
      for (int i = 0; i < 3; i++)
         step(3'b110, 3'b000, HTRANS_SEQ, HBURST_WRAP8, 1'b0, 3'b100, 2'd2, 1'b0,
              $sformatf("wrap8_wait_%0d", i));
      for (int i = 3; i <= 7; i++)
         step(3'b110, 3'b000, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 3'b100, 2'd2, 1'b0,
              $sformatf("wrap8_b%0d", i));
      step(3'b110, 3'b000, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 3'b010, 2'd2, 1'b0, "wrap8_handover");

      // M0 locked INCR sequence while M1 requests.
      step(3'b001, 3'b001, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 3'b001, 2'd1, 1'b0, "lock_grant_m0");
      step(3'b011, 3'b001, HTRANS_NONSEQ, HBURST_INCR,   1'b1, 3'b001, 2'd0, 1'b1, "lock_start");
      step(3'b011, 3'b001, HTRANS_SEQ,    HBURST_INCR,   1'b1, 3'b001, 2'd0, 1'b1, "lock_seq1");
      step(3'b011, 3'b001, HTRANS_SEQ,    HBURST_INCR,   1'b1, 3'b001, 2'd0, 1'b1, "lock_seq2");
      step(3'b011, 3'b001, HTRANS_IDLE,   HBURST_INCR,   1'b1, 3'b001, 2'd0, 1'b1, "lock_idle_held");
      step(3'b010, 3'b000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 3'b001, 2'd0, 1'b0, "lock_seq_unlocked");
      step(3'b010, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 3'b010, 2'd0, 1'b0, "lock_release");

      // M1 INCR16, reset pulse between clock edges after the fifth beat.
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, 3'b010, 2'd1, 1'b0, "incr16_b1");
      for (int i = 2; i <= 5; i++)
         step(3'b110, 3'b000, HTRANS_SEQ, HBURST_INCR16, 1'b1, 3'b010, 2'd1, 1'b0,
              $sformatf("incr16_b%0d", i));
      @(negedge HCLK);
      #1;
      drive(3'b110, 3'b000, HTRANS_SEQ, HBURST_INCR16, 1'b1);
      HRESET = 1'b1;
      #2;
      HRESET = 1'b0;
      expect_at(cyc + 1, 3'b010, 2'd0, 1'b0, "post_reset_arb");
      @(posedge HCLK);
      #1;
      step(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'b100, 2'd1, 1'b0, "post_reset_rr");

      @(negedge HCLK);
      #1;
      while (q_cyc.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: never sampled, required %b", q_name.pop_front(), q_val.pop_front());
         void'(q_cyc.pop_front());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
